// File: rtl/power_accel_pkg.sv
// power_accel_pkg: shared definitions for the power accelerator.
//   - register word offsets decoded from address[2:0]
//   - CTRL / STATUS bit indices
//   - FSM state enum (IDLE, RUN)
//   - default data and exponent widths
package power_accel_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_EXP_W  = 32;

    localparam logic [2:0] CTRL_OFS   = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd1;
    localparam logic [2:0] BASE_OFS   = 3'd2;
    localparam logic [2:0] EXP_OFS    = 3'd3;
    localparam logic [2:0] RESULT_OFS = 3'd4;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_CLR_DONE_BIT = 1;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_OVF_BIT  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/power_accelerator_if.sv
// power_accelerator_if: Avalon-MM slave bus of the power accelerator.
//   address   : word address, only [2:0] decoded, [23:3] must be zero
//   write     : write strobe, writedata taken on the rising edge it is high
//   writedata : write data
//   read      : read strobe
//   readdata  : registered read data
// Handshake: there is no waitrequest. A strobe high on a rising edge is a
// complete transfer in that cycle; readdata for a read issued in cycle c is
// valid in cycle c+1 and holds until the next read. Read and write in the
// same cycle: the write lands and readdata carries the pre-write value.
interface power_accelerator_if;
    logic [23:0] address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface

// File: rtl/power_core.sv
// power_core: iterative square-and-multiply engine, base^exp mod 2^DATA_W.
// Optional feature macro: POWER_ACCEL_OVF_EN (enables upper-half overflow
// detection; without it ovf is constant 0 and no wide products exist).
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   start          : request; accepted only in IDLE
//   base, exp      : operands, latched on an accepted start
//   busy           : high from the cycle after start until completion
//   done_pulse     : one-cycle high in the completing cycle (RUN, e == 0)
//   result         : running product p; valid while done_pulse is high
//   ovf            : sticky overflow flag, cleared on an accepted start
//   state          : current FSM state (debug)
module power_core
    import power_accel_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int EXP_W  = DEFAULT_EXP_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [EXP_W-1:0]  exp,
    output logic              busy,
    output logic              done_pulse,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output state_t            state
);

    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] p_q;
    logic [EXP_W-1:0]  e_q;
    logic [DATA_W-1:0] pb_lo;
    logic [DATA_W-1:0] bb_lo;
    logic              ovf_hit;

`ifdef POWER_ACCEL_OVF_EN
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] p_ext;
    logic [2*DATA_W-1:0] pb_full;
    logic [2*DATA_W-1:0] bb_full;

    assign b_ext   = {{DATA_W{1'b0}}, b_q};
    assign p_ext   = {{DATA_W{1'b0}}, p_q};
    assign pb_full = p_ext * b_ext;
    assign bb_full = b_ext * b_ext;
    assign pb_lo   = pb_full[DATA_W-1:0];
    assign bb_lo   = bb_full[DATA_W-1:0];
    // The final squaring (e>>1 == 0) is never used, so its overflow is ignored.
    assign ovf_hit = (e_q[0] && (pb_full[2*DATA_W-1:DATA_W] != '0)) ||
                     ((bb_full[2*DATA_W-1:DATA_W] != '0) && ((e_q >> 1) != '0));
`else
    assign pb_lo   = p_q * b_q;
    assign bb_lo   = b_q * b_q;
    assign ovf_hit = 1'b0;
`endif

    // Completion is decoded from registers so the top can capture the
    // result on the same edge that returns the FSM to IDLE.
    assign done_pulse = (state == RUN) && (e_q == '0);
    assign result     = p_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            b_q   <= '0;
            p_q   <= '0;
            e_q   <= '0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_q   <= base;
                        e_q   <= exp;
                        p_q   <= {{(DATA_W-1){1'b0}}, 1'b1};
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (e_q != '0) begin
                        if (e_q[0]) begin
                            p_q <= pb_lo;
                        end
                        b_q <= bb_lo;
                        e_q <= e_q >> 1;
                        if (ovf_hit) begin
                            ovf <= 1'b1;
                        end
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/power_accelerator.sv
// power_accelerator: Avalon-MM slave computing BASE^EXP mod 2^DATA_W.
// Optional feature macro: POWER_ACCEL_OVF_EN (STATUS.OVF overflow reporting).
// Register map (word offsets): 0 CTRL (WO: bit0 START, bit1 CLR_DONE),
//   1 STATUS (RO: bit0 BUSY, bit1 DONE, bit2 OVF), 2 BASE (RW), 3 EXP (RW),
//   4 RESULT (RO). Offsets 5-7 and address[23:3] != 0 read 0, ignore writes.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   bus            : Avalon-MM slave (power_accelerator_if.slave)
//   conduit_export : mirror of RESULT
//   state          : engine FSM state (debug)
module power_accelerator
    import power_accel_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int EXP_W  = DEFAULT_EXP_W
) (
    input  logic                clock,
    input  logic                reset_n,
    power_accelerator_if.slave  bus,
    output logic [DATA_W-1:0]   conduit_export,
    output state_t              state
);

    logic              sel_ok;
    logic [2:0]        ofs;
    logic              wr_en;
    logic              start_req;
    logic              clr_req;

    logic              busy;
    logic              done_pulse;
    logic [DATA_W-1:0] core_result;
    logic              core_ovf;

    logic [DATA_W-1:0] base_q;
    logic [EXP_W-1:0]  exp_q;
    logic [DATA_W-1:0] result_q;
    logic              done_q;
    logic [31:0]       rd_mux;
    logic [31:0]       readdata_q;

    assign sel_ok    = (bus.address[23:3] == '0);
    assign ofs       = bus.address[2:0];
    assign wr_en     = bus.write && sel_ok;
    assign start_req = wr_en && (ofs == CTRL_OFS) && bus.writedata[CTRL_START_BIT];
    assign clr_req   = wr_en && (ofs == CTRL_OFS) && bus.writedata[CTRL_CLR_DONE_BIT];

    power_core #(
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W)
    ) u_core (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start_req),
        .base       (base_q),
        .exp        (exp_q),
        .busy       (busy),
        .done_pulse (done_pulse),
        .result     (core_result),
        .ovf        (core_ovf),
        .state      (state)
    );

    always_comb begin
        rd_mux = '0;
        if (sel_ok) begin
            case (ofs)
                STATUS_OFS: begin
                    rd_mux[STAT_BUSY_BIT] = busy;
                    rd_mux[STAT_DONE_BIT] = done_q;
                    rd_mux[STAT_OVF_BIT]  = core_ovf;
                end
                BASE_OFS:   rd_mux[DATA_W-1:0] = base_q;
                EXP_OFS:    rd_mux[EXP_W-1:0]  = exp_q;
                RESULT_OFS: rd_mux[DATA_W-1:0] = result_q;
                default:    rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            exp_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            if (wr_en && (ofs == BASE_OFS)) begin
                base_q <= bus.writedata[DATA_W-1:0];
            end
            if (wr_en && (ofs == EXP_OFS)) begin
                exp_q <= bus.writedata[EXP_W-1:0];
            end
            // While busy, CTRL writes are ignored entirely; done_pulse only
            // occurs while busy, so it never competes with a CTRL write.
            if (done_pulse) begin
                result_q <= core_result;
                done_q   <= 1'b1;
            end else if (!busy && (start_req || clr_req)) begin
                done_q <= 1'b0;
            end
            // rd_mux sees pre-edge register values, so a simultaneous
            // write is not reflected in this read.
            if (bus.read) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign bus.readdata   = readdata_q;
    assign conduit_export = result_q;

endmodule

// File: tb/tb_power_accelerator.sv
// tb_power_accelerator: self-checking bench for power_accelerator.
// Optional feature macro: POWER_ACCEL_OVF_EN (changes expected STATUS.OVF).
module tb_power_accelerator;
    import power_accel_pkg::*;

`ifdef POWER_ACCEL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam logic [23:0] CTRL_A   = 24'd0;
    localparam logic [23:0] STATUS_A = 24'd1;
    localparam logic [23:0] BASE_A   = 24'd2;
    localparam logic [23:0] EXP_A    = 24'd3;
    localparam logic [23:0] RESULT_A = 24'd4;

    // ---------------- clock / reset ----------------
    logic        clock;
    logic        reset_n;
    logic [31:0] conduit_export;
    state_t      dbg_state;

    power_accelerator_if bus_if ();

    power_accelerator dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus_if.slave),
        .conduit_export (conduit_export),
        .state          (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, want);
        end
    endtask

    // Reference: plain arithmetic on the mathematical power.
    // OVF is set exactly when the true BASE^EXP does not fit in 32 bits.
    function automatic void model(input logic [31:0] b, input logic [31:0] e,
                                  output logic [31:0] res, output bit ovf, output int k);
        logic [31:0] r;
        logic [63:0] acc;
        k = 0;
        for (int i = 0; i < 32; i++) if (e[i]) k = i + 1;
        ovf = 1'b0;
        if (b > 32'd1) begin
            acc = 64'd1;
            for (int unsigned i = 0; i < e; i++) begin
                acc = acc * {32'd0, b};
                if (acc[63:32] != 32'd0) begin
                    ovf = 1'b1;
                    break;
                end
            end
        end
        if (e <= 32'd4096) begin
            r = 32'd1;
            for (int unsigned i = 0; i < e; i++) r = r * b;
        end else if (!b[0]) begin
            r = 32'd0;                 // 2^32 divides b^e once e >= 32
        end else if (b == 32'd1) begin
            r = 32'd1;
        end else begin
            r = e[0] ? b : 32'd1;      // b == -1 mod 2^32
        end
        res = r;
    endfunction

    // ---------------- driver tasks (entered and left on a negedge) ----------------
    task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
        bus_if.address   = a;
        bus_if.writedata = d;
        bus_if.write     = 1'b1;
        @(negedge clock);
        bus_if.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [23:0] a, output logic [31:0] d);
        bus_if.address = a;
        bus_if.read    = 1'b1;
        @(negedge clock);
        bus_if.read    = 1'b0;
        d = bus_if.readdata;
    endtask

    task automatic run_op(input logic [31:0] b, input logic [31:0] e, input string tag);
        logic [31:0] res;
        logic [31:0] st;
        logic [31:0] rd;
        logic [31:0] want;
        bit          ovf;
        int          k;
        int          n;
        model(b, e, res, ovf, k);
        exp_q.push_back(res);
        bus_write(BASE_A, b);
        bus_write(EXP_A, e);
        bus_write(CTRL_A, 32'h1);
        bus_read(STATUS_A, st);
        check({tag, "_busy"}, st, 32'h1);
        n = 1;
        while (n <= 40) begin
            bus_read(STATUS_A, st);
            if (st[1]) break;
            n++;
        end
        check({tag, "_lat"}, n, k + 1);
        want = exp_q.pop_front();
        check({tag, "_status"}, st, {29'd0, ovf & OVF_EN, 2'b10});
        bus_read(RESULT_A, rd);
        check({tag, "_result"}, rd, want);
        check({tag, "_conduit"}, conduit_export, want);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] st;
        logic [31:0] b;
        logic [31:0] e;
        logic [31:0] res;
        bit          ovf;
        int          k;
        int          n;

        reset_n          = 1'b0;
        bus_if.address   = '0;
        bus_if.write     = 1'b0;
        bus_if.writedata = '0;
        bus_if.read      = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Reset state
        check("rst_readdata", bus_if.readdata, 32'd0);
        check("rst_conduit", conduit_export, 32'd0);
        check("rst_state", dbg_state, IDLE);
        for (int i = 0; i < 8; i++) begin
            bus_read(24'(i), rd);
            check($sformatf("rst_ofs%0d", i), rd, 32'd0);
        end

        // Directed cases
        run_op(32'd3, 32'd5, "b3e5");
        run_op(32'd0, 32'd0, "b0e0");
        run_op(32'd2, 32'd31, "b2e31");
        run_op(32'd2, 32'd32, "b2e32");
        run_op(32'd7, 32'd1, "b7e1");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "worst");

        bus_read(CTRL_A, rd);
        check("ctrl_read", rd, 32'd0);

        // Register readback, unmapped offsets and high-address aliasing
        bus_write(BASE_A, 32'h1234_5678);
        bus_write(EXP_A, 32'h0000_00AB);
        bus_write(24'h00_000A, 32'hDEAD_BEEF);   // address[23:3] != 0
        bus_read(24'h00_000A, rd);
        check("hi_addr_read", rd, 32'd0);
        bus_read(BASE_A, rd);
        check("base_rb", rd, 32'h1234_5678);
        bus_read(EXP_A, rd);
        check("exp_rb", rd, 32'h0000_00AB);
        bus_write(24'd6, 32'h5555_5555);
        bus_read(24'd6, rd);
        check("ofs6_read", rd, 32'd0);

        // Read and write together: readdata carries the pre-write value
        bus_if.address   = BASE_A;
        bus_if.writedata = 32'hABCD_0001;
        bus_if.write     = 1'b1;
        bus_if.read      = 1'b1;
        @(negedge clock);
        bus_if.write = 1'b0;
        bus_if.read  = 1'b0;
        check("rw_prewrite", bus_if.readdata, 32'h1234_5678);
        bus_read(BASE_A, rd);
        check("rw_postwrite", rd, 32'hABCD_0001);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin b = $urandom; e = $urandom_range(0, 300); end
                1: begin b = $urandom & 32'hFFFF_FFFE; e = $urandom; end
                2: begin
                    case ($urandom_range(0, 2))
                        0: b = 32'd0;
                        1: b = 32'd1;
                        default: b = 32'hFFFF_FFFF;
                    endcase
                    e = $urandom;
                end
                default: begin b = $urandom_range(0, 20); e = $urandom_range(0, 40); end
            endcase
            run_op(b, e, $sformatf("rnd%0d", i));
        end

        // Mid-RUN writes: second START, EXP/BASE updates, START+CLR_DONE
        model(32'hFFFF_FFFF, 32'h8000_0001, res, ovf, k);
        bus_write(BASE_A, 32'hFFFF_FFFF);
        bus_write(EXP_A, 32'h8000_0001);
        bus_write(CTRL_A, 32'h1);                 // cycle t
        bus_write(EXP_A, 32'd1);                  // t+1
        bus_write(CTRL_A, 32'h1);                 // t+2
        bus_write(CTRL_A, 32'h3);                 // t+3
        bus_write(BASE_A, 32'd5);                 // t+4
        n = 5;
        while (n <= 45) begin
            bus_read(STATUS_A, st);
            if (st[1]) break;
            n++;
        end
        check("mid_lat", n, k + 2);
        check("mid_status", st, {29'd0, ovf & OVF_EN, 2'b10});
        bus_read(RESULT_A, rd);
        check("mid_result", rd, res);
        bus_read(EXP_A, rd);
        check("mid_exp_reg", rd, 32'd1);
        bus_write(CTRL_A, 32'h2);                 // CLR_DONE in IDLE
        bus_read(STATUS_A, st);
        check("clr_done", st, {29'd0, ovf & OVF_EN, 2'b00});

        // START and CLR_DONE together in IDLE: START wins (5^1)
        bus_write(CTRL_A, 32'h3);
        bus_read(STATUS_A, st);
        check("startclr_busy", st, 32'h1);
        n = 0;
        while (n < 40) begin
            bus_read(STATUS_A, st);
            if (st[1]) break;
            n++;
        end
        check("startclr_status", st, 32'h2);
        bus_read(RESULT_A, rd);
        check("startclr_result", rd, 32'd5);

        // Reset mid-RUN
        bus_write(BASE_A, 32'd3);
        bus_write(EXP_A, 32'hFFFF_FFFF);
        bus_write(CTRL_A, 32'h1);
        repeat (3) @(negedge clock);
        bus_read(STATUS_A, st);
        check("pre_rst_busy", st[0], 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("mrst_readdata", bus_if.readdata, 32'd0);
        check("mrst_conduit", conduit_export, 32'd0);
        check("mrst_state", dbg_state, IDLE);
        for (int i = 1; i < 5; i++) begin
            bus_read(24'(i), rd);
            check($sformatf("mrst_ofs%0d", i), rd, 32'd0);
        end
        run_op(32'd3, 32'd5, "post_rst");

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
